// File: rtl/ddr_rd_arbiter_pkg.sv
// rtl/ddr_rd_arbiter_pkg.sv - shared DDR read request/tag types
package ddr_rd_arbiter_pkg;

   localparam int DDR_RD_ADDR_W    = 32;
   localparam int DDR_RD_TAG_ID_W  = 3;
   localparam int DDR_RD_TAG_LEN_W = 8;
   localparam int DDR_RD_MAX_LEN   = 15;

   typedef struct packed {
      logic [DDR_RD_ADDR_W-1:0] addr;
   } ddr_rd_t;

   // Tag fields are sized for the widest supported configuration (8 requesters).
   typedef struct packed {
      logic [DDR_RD_TAG_ID_W-1:0]  id;
      logic [DDR_RD_TAG_LEN_W-1:0] len;
   } ddr_rd_tag_t;

endpackage

// File: rtl/ddr_rd_arbiter_rr.sv
// rtl/ddr_rd_arbiter_rr.sv - combinational one-hot round-robin pick
module rr_arbiter #(
   parameter int N = 2,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx
);

   logic found;

   // First pass covers indices above the last grant, second pass wraps from 0.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i > int'(last))) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = W'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = W'(i);
         end
      end
   end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// rtl/ddr_rd_arbiter.sv - round-robin DDR read arbiter with in-order response steering
module ddr_rd_arbiter
   import ddr_rd_arbiter_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   parameter int LEN_W           = 4,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                                 Clk,
   input  logic                                 Rst_n,
   input  logic [NUM_REQ*$bits(ddr_rd_t)-1:0]   req_data,
   input  logic [NUM_REQ*LEN_W-1:0]             req_len,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   output logic [$bits(ddr_rd_t)-1:0]           ddr_rd_req_data,
   output logic                                 ddr_rd_req_valid,
   input  logic                                 ddr_rd_req_almost_full,
   input  logic [511:0]                         ddr_rd_resp_data,
   input  logic                                 ddr_rd_resp_valid,
   output logic                                 ddr_rd_resp_ready,
   output logic [511:0]                         resp_data,
   output logic [NUM_REQ-1:0]                   resp_valid,
   output logic                                 resp_last,
   input  logic [NUM_REQ-1:0]                   resp_ready,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
   output logic                                 err_orphan
);

   localparam int DW    = $bits(ddr_rd_t);
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int OCC_W = PTR_W + 1;

   logic [ID_W-1:0]    last_grant;
   logic [ID_W-1:0]    gnt_idx;
   logic [NUM_REQ-1:0] gnt;
   logic               grant_fire;
   logic [LEN_W-1:0]   gnt_len;

   ddr_rd_tag_t        tag_mem [MAX_OUTSTANDING];
   ddr_rd_tag_t        push_tag;
   ddr_rd_tag_t        head;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [OCC_W-1:0]   count;
   logic [LEN_W-1:0]   beat_cnt;
   logic [NUM_REQ-1:0] head_sel;
   logic               empty;
   logic               full;
   logic               beat_fire;
   logic               pop;

   rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_rr (
      .req     (req_valid),
      .last    (last_grant),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign empty      = (count == '0);
   assign full       = (count == OCC_W'(MAX_OUTSTANDING));
   assign grant_fire = (|req_valid) && !ddr_rd_req_almost_full && !full;
   assign req_ready  = grant_fire ? gnt : '0;
   assign gnt_len    = req_len[gnt_idx*LEN_W +: LEN_W];

   // A zero-length request is still forwarded but expects exactly one beat back.
   always_comb begin
      push_tag     = '0;
      push_tag.id  = DDR_RD_TAG_ID_W'(gnt_idx);
      push_tag.len = DDR_RD_TAG_LEN_W'(gnt_len);
      if (gnt_len == '0) begin
         push_tag.len = DDR_RD_TAG_LEN_W'(1);
      end
   end

   assign head      = tag_mem[rd_ptr];
   assign head_sel  = NUM_REQ'(1) << head.id;
   assign resp_last = !empty && (DDR_RD_TAG_LEN_W'(beat_cnt) == (head.len - DDR_RD_TAG_LEN_W'(1)));
   assign resp_valid = (ddr_rd_resp_valid && !empty) ? head_sel : '0;
   assign resp_data  = ddr_rd_resp_data;
   // With no tag outstanding, beats are orphans and are swallowed.
   assign ddr_rd_resp_ready = empty ? ddr_rd_resp_valid : (|(resp_ready & head_sel));
   assign beat_fire   = ddr_rd_resp_valid && !empty && (|(resp_ready & head_sel));
   assign pop         = beat_fire && resp_last;
   assign outstanding = count;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ddr_rd_req_valid <= 1'b0;
         ddr_rd_req_data  <= '0;
         last_grant       <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         beat_cnt         <= '0;
         err_orphan       <= 1'b0;
      end else begin
         ddr_rd_req_valid <= grant_fire;
         if (grant_fire) begin
            ddr_rd_req_data <= req_data[gnt_idx*DW +: DW];
            last_grant      <= gnt_idx;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (beat_fire) begin
            beat_cnt <= pop ? '0 : beat_cnt + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (grant_fire && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !grant_fire) begin
            count <= count - 1'b1;
         end
         if (ddr_rd_resp_valid && empty) begin
            err_orphan <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (grant_fire) begin
         tag_mem[wr_ptr] <= push_tag;
      end
   end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb/tb_ddr_rd_arbiter.sv - scoreboard bench for ddr_rd_arbiter
module tb_ddr_rd_arbiter;
   import ddr_rd_arbiter_pkg::*;

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b0;
   logic [63:0]   req_data = '0;
   logic [7:0]    req_len = '0;
   logic [1:0]    req_valid = '0;
   logic [1:0]    req_ready;
   logic [31:0]   ddr_rd_req_data;
   logic          ddr_rd_req_valid;
   logic          ddr_rd_req_almost_full = 1'b0;
   logic [511:0]  ddr_rd_resp_data = '0;
   logic          ddr_rd_resp_valid = 1'b0;
   logic          ddr_rd_resp_ready;
   logic [511:0]  resp_data;
   logic [1:0]    resp_valid;
   logic          resp_last;
   logic [1:0]    resp_ready = 2'b11;
   logic [4:0]    outstanding;
   logic          err_orphan;

   typedef struct {
      int          id;
      bit          last;
      logic [31:0] seq;
   } exp_resp_t;

   logic [31:0] exp_req[$];
   exp_resp_t   exp_resp[$];
   logic [31:0] exp_seq = 0;
   logic [31:0] rsp_seq = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mon_req_e;
   exp_resp_t   mon_resp_e;

   always #5 Clk = ~Clk;

   ddr_rd_arbiter #(.NUM_REQ(2), .ID_W(1), .LEN_W(4), .MAX_OUTSTANDING(16)) dut (
      .Clk                    (Clk),
      .Rst_n                  (Rst_n),
      .req_data               (req_data),
      .req_len                (req_len),
      .req_valid              (req_valid),
      .req_ready              (req_ready),
      .ddr_rd_req_data        (ddr_rd_req_data),
      .ddr_rd_req_valid       (ddr_rd_req_valid),
      .ddr_rd_req_almost_full (ddr_rd_req_almost_full),
      .ddr_rd_resp_data       (ddr_rd_resp_data),
      .ddr_rd_resp_valid      (ddr_rd_resp_valid),
      .ddr_rd_resp_ready      (ddr_rd_resp_ready),
      .resp_data              (resp_data),
      .resp_valid             (resp_valid),
      .resp_last              (resp_last),
      .resp_ready             (resp_ready),
      .outstanding            (outstanding),
      .err_orphan             (err_orphan)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int id, input logic [31:0] addr, input int nbeats);
      exp_req.push_back(addr);
      for (int b = 0; b < nbeats; b++) begin
         exp_resp.push_back('{id: id, last: (b == nbeats - 1), seq: exp_seq});
         exp_seq++;
      end
   endtask

   // Called just after a rising edge; the grant is taken on the following edge.
   task automatic issue(input int id, input logic [31:0] addr, input logic [3:0] len, input int nbeats);
      logic [1:0] oh;
      oh = 2'b01 << id;
      req_valid[id] = 1'b1;
      req_data[id*32 +: 32] = addr;
      req_len[id*4 +: 4] = len;
      @(negedge Clk);
      chk("grant", {62'd0, req_ready}, {62'd0, oh});
      push_exp(id, addr, nbeats);
      @(posedge Clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic send_beats(input int n);
      int wait_cnt;
      for (int b = 0; b < n; b++) begin
         ddr_rd_resp_valid = 1'b1;
         ddr_rd_resp_data = {16{rsp_seq}};
         wait_cnt = 0;
         @(negedge Clk);
         while (!ddr_rd_resp_ready && wait_cnt < 20) begin
            @(negedge Clk);
            wait_cnt++;
         end
         chk("beat_accept", {63'd0, ddr_rd_resp_ready}, 64'd1);
         @(posedge Clk); #1;
         rsp_seq++;
      end
      ddr_rd_resp_valid = 1'b0;
   endtask

   always @(negedge Clk) begin
      if (Rst_n && ddr_rd_req_valid) begin
         checks++;
         if (exp_req.size() == 0) begin
            errors++;
            $display("FAIL req_fwd: unexpected request %h", ddr_rd_req_data);
         end else begin
            mon_req_e = exp_req.pop_front();
            if (ddr_rd_req_data !== mon_req_e) begin
               errors++;
               $display("FAIL req_fwd: got %h expected %h", ddr_rd_req_data, mon_req_e);
            end
         end
      end
      if (Rst_n && (|resp_valid) && ddr_rd_resp_ready) begin
         checks++;
         if (exp_resp.size() == 0) begin
            errors++;
            $display("FAIL resp: unexpected beat valid=%b", resp_valid);
         end else begin
            mon_resp_e = exp_resp.pop_front();
            if (resp_valid !== (2'b01 << mon_resp_e.id) || resp_last !== mon_resp_e.last ||
                resp_data !== {16{mon_resp_e.seq}}) begin
               errors++;
               $display("FAIL resp: got valid=%b last=%b seq=%h expected id=%0d last=%b seq=%h",
                        resp_valid, resp_last, resp_data[31:0], mon_resp_e.id, mon_resp_e.last, mon_resp_e.seq);
            end
         end
      end
   end

   initial begin
      // reset state
      @(negedge Clk);
      chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
      chk("rst_req_valid", {63'd0, ddr_rd_req_valid}, 64'd0);
      chk("rst_outstanding", {59'd0, outstanding}, 64'd0);
      chk("rst_err_orphan", {63'd0, err_orphan}, 64'd0);
      chk("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
      chk("rst_resp_ready", {63'd0, ddr_rd_resp_ready}, 64'd0);
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      @(posedge Clk); #1;

      // single request, len 3
      issue(0, 32'h0000_0100, 4'd3, 3);
      @(negedge Clk);
      chk("single_req_valid", {63'd0, ddr_rd_req_valid}, 64'd1);
      chk("single_outstanding", {59'd0, outstanding}, 64'd1);
      @(posedge Clk); #1;
      send_beats(3);
      @(negedge Clk);
      chk("single_drained", {59'd0, outstanding}, 64'd0);
      @(posedge Clk); #1;

      // fairness: last grant was 0, so the rotation starts at 1
      req_data = {32'h0000_0300, 32'h0000_0200};
      req_len = {4'd1, 4'd1};
      req_valid = 2'b11;
      for (int k = 0; k < 8; k++) begin
         @(negedge Clk);
         chk("fair_grant", {62'd0, req_ready}, (k % 2 == 0) ? 64'd2 : 64'd1);
         push_exp((k % 2 == 0) ? 1 : 0, (k % 2 == 0) ? 32'h0000_0300 : 32'h0000_0200, 1);
         @(posedge Clk); #1;
      end
      req_valid = 2'b00;
      @(negedge Clk);
      chk("fair_outstanding", {59'd0, outstanding}, 64'd8);
      @(posedge Clk); #1;
      send_beats(8);

      // backpressure
      ddr_rd_req_almost_full = 1'b1;
      req_valid[1] = 1'b1;
      req_data[63:32] = 32'h0000_0400;
      req_len[7:4] = 4'd1;
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         chk("bp_no_grant", {62'd0, req_ready}, 64'd0);
         @(posedge Clk); #1;
      end
      ddr_rd_req_almost_full = 1'b0;
      @(negedge Clk);
      chk("bp_release_grant", {62'd0, req_ready}, 64'd2);
      push_exp(1, 32'h0000_0400, 1);
      @(posedge Clk); #1;
      req_valid = 2'b00;
      @(negedge Clk);
      chk("bp_req_valid", {63'd0, ddr_rd_req_valid}, 64'd1);
      @(posedge Clk); #1;
      send_beats(1);

      // outstanding limit
      req_valid[0] = 1'b1;
      req_data[31:0] = 32'h0000_0500;
      req_len[3:0] = 4'd1;
      for (int k = 0; k < 16; k++) begin
         @(negedge Clk);
         chk("fill_grant", {62'd0, req_ready}, 64'd1);
         push_exp(0, 32'h0000_0500, 1);
         @(posedge Clk); #1;
      end
      @(negedge Clk);
      chk("full_hold", {62'd0, req_ready}, 64'd0);
      chk("full_outstanding", {59'd0, outstanding}, 64'd16);
      @(posedge Clk); #1;
      ddr_rd_resp_valid = 1'b1;
      ddr_rd_resp_data = {16{rsp_seq}};
      @(negedge Clk);
      chk("full_pop_ready", {63'd0, ddr_rd_resp_ready}, 64'd1);
      chk("full_no_bypass", {62'd0, req_ready}, 64'd0);
      @(posedge Clk); #1;
      rsp_seq++;
      ddr_rd_resp_valid = 1'b0;
      @(negedge Clk);
      chk("full_17th_grant", {62'd0, req_ready}, 64'd1);
      chk("full_after_pop", {59'd0, outstanding}, 64'd15);
      push_exp(0, 32'h0000_0500, 1);
      @(posedge Clk); #1;
      req_valid = 2'b00;
      send_beats(16);

      // response stall mid-burst
      issue(1, 32'h0000_0600, 4'd4, 4);
      send_beats(2);
      ddr_rd_resp_valid = 1'b1;
      ddr_rd_resp_data = {16{rsp_seq}};
      resp_ready = 2'b01;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         chk("stall_ready", {63'd0, ddr_rd_resp_ready}, 64'd0);
         chk("stall_valid", {62'd0, resp_valid}, 64'd2);
         chk("stall_last", {63'd0, resp_last}, 64'd0);
         @(posedge Clk); #1;
      end
      resp_ready = 2'b11;
      send_beats(2);

      // orphan beat
      ddr_rd_resp_valid = 1'b1;
      ddr_rd_resp_data = {16{32'hdead_beef}};
      @(negedge Clk);
      chk("orphan_ready", {63'd0, ddr_rd_resp_ready}, 64'd1);
      chk("orphan_no_valid", {62'd0, resp_valid}, 64'd0);
      @(posedge Clk); #1;
      ddr_rd_resp_valid = 1'b0;
      @(negedge Clk);
      chk("orphan_flag", {63'd0, err_orphan}, 64'd1);
      chk("orphan_outstanding", {59'd0, outstanding}, 64'd0);
      @(posedge Clk); #1;

      // zero-length request returns one beat; orphan flag stays sticky
      issue(0, 32'h0000_0680, 4'd0, 1);
      send_beats(1);
      @(negedge Clk);
      chk("orphan_sticky", {63'd0, err_orphan}, 64'd1);
      chk("len0_drained", {59'd0, outstanding}, 64'd0);
      @(posedge Clk); #1;

      // asynchronous reset mid-burst
      issue(0, 32'h0000_0700, 4'd3, 3);
      send_beats(1);
      ddr_rd_resp_valid = 1'b1;
      ddr_rd_resp_data = {16{rsp_seq}};
      #2;
      Rst_n = 1'b0;
      ddr_rd_resp_valid = 1'b0;
      #1;
      chk("arst_outstanding", {59'd0, outstanding}, 64'd0);
      chk("arst_resp_valid", {62'd0, resp_valid}, 64'd0);
      chk("arst_resp_last", {63'd0, resp_last}, 64'd0);
      chk("arst_err_orphan", {63'd0, err_orphan}, 64'd0);
      chk("arst_resp_ready", {63'd0, ddr_rd_resp_ready}, 64'd0);
      exp_resp.delete();
      exp_seq = rsp_seq;
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      @(posedge Clk); #1;
      issue(0, 32'h0000_0800, 4'd2, 2);
      send_beats(2);
      @(negedge Clk);
      chk("arst_recovered", {59'd0, outstanding}, 64'd0);
      chk("exp_req_empty", 64'(exp_req.size()), 64'd0);
      chk("exp_resp_empty", 64'(exp_resp.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
